// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg -- shared types and default constants for store_monitor.
//   state_e            : verdict FSM state encoding
//   DEF_*              : default pass/scratch address, pass data, timeout length
// Optional feature macro: STORE_MONITOR_TIMEOUT_EN adds the TIMEOUT state.
package store_monitor_pkg;

    localparam logic [31:0] DEF_PASS_ADDR      = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA      = 32'd7;
    localparam logic [31:0] DEF_SCRATCH_ADDR   = 32'd80;
    localparam int          DEF_TIMEOUT_CYCLES = 100;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
`ifdef STORE_MONITOR_TIMEOUT_EN
        , TIMEOUT
`endif
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that sticks at all-ones instead of wrapping.
//   clk, reset : clock, synchronous active-high clear
//   en         : count this cycle
//   count      : current value
module sat_counter
    import store_monitor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/store_monitor.sv
// store_monitor -- watches processor data-memory stores and reaches a sticky
// pass/fail verdict.
//   clk, reset                         : clock, synchronous active-high reset
//   write_enab, data_addr, write_data  : store strobe, address, data
//   done, pass, fail                   : registered verdict (done = pass|fail)
//   store_count                        : stores accepted while running (saturating)
//   cycle_count                        : cycles spent running (saturating)
// Optional feature macro: STORE_MONITOR_TIMEOUT_EN -- fail after TIMEOUT_CYCLES
// run cycles with no verdict.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enab,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count
);

`ifdef STORE_MONITOR_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

    state_e state_q, state_d;
    logic   pass_q, pass_d;
    logic   fail_q, fail_d;
    logic   store_en;
    logic   cycle_en;

    always_comb begin
        state_d  = state_q;
        store_en = 1'b0;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                // An unknown strobe cannot be trusted either way, so it ends the run.
                if ($isunknown(write_enab)) begin
                    state_d = FAIL;
                end else if (write_enab) begin
                    store_en = 1'b1;
                    if ($isunknown({data_addr, write_data}))
                        state_d = FAIL;
                    else if (data_addr == PASS_ADDR)
                        state_d = (write_data == PASS_DATA) ? PASS : FAIL;
                    else if (data_addr != SCRATCH_ADDR)
                        state_d = FAIL;
                end
`ifdef STORE_MONITOR_TIMEOUT_EN
                // Only reached with no store this cycle, so a store verdict wins.
                else if (cycle_count == TIMEOUT_LAST) begin
                    state_d = TIMEOUT;
                end
`endif
            end
            default: state_d = state_q;
        endcase

        pass_d = (state_d == PASS);
`ifdef STORE_MONITOR_TIMEOUT_EN
        fail_d = (state_d == FAIL) || (state_d == TIMEOUT);
`else
        fail_d = (state_d == FAIL);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign cycle_en = (state_q == RUN);

    sat_counter #(.WIDTH(16)) u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (store_en),
        .count (store_count)
    );

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cycle_en),
        .count (cycle_count)
    );

    assign pass = pass_q;
    assign fail = fail_q;
    assign done = pass_q | fail_q;

endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enab = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        done, pass, fail;
    logic [15:0] store_count;
    logic [31:0] cycle_count;

    logic        sc_reset = 1'b1;
    logic        sc_en = 1'b0;
    logic [2:0]  sc_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_monitor #(.TIMEOUT_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_enab  (write_enab),
        .data_addr   (data_addr),
        .write_data  (write_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .store_count (store_count),
        .cycle_count (cycle_count)
    );

    sat_counter #(.WIDTH(3)) u_sat (
        .clk   (clk),
        .reset (sc_reset),
        .en    (sc_en),
        .count (sc_count)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        pass;
        logic        fail;
        logic [15:0] sc;
        logic [31:0] cc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic dn, input logic p,
                       input logic f, input logic [15:0] sc, input logic [31:0] cc);
        vq.push_back('{rst, we, a, d, dn, p, f, sc, cc});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic p, input logic f,
                           input logic [15:0] sc, input logic [31:0] cc);
        chk({nm, ".done"}, {31'd0, done}, {31'd0, p | f});
        chk({nm, ".pass"}, {31'd0, pass}, {31'd0, p});
        chk({nm, ".fail"}, {31'd0, fail}, {31'd0, f});
        chk({nm, ".sc"}, {16'd0, store_count}, {16'd0, sc});
        chk({nm, ".cc"}, cycle_count, cc);
    endtask

    task automatic step(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        reset = rst; write_enab = we; data_addr = a; write_data = d;
        @(posedge clk); #1;
        write_enab = 1'b0;
    endtask

    initial begin
        // ---------------- table: rst we addr data | done pass fail sc cc
        // 84/6 fails; a later 84/7 is ignored
        add(1, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 84, 6, 1, 0, 1, 1, 1);
        add(0, 1, 84, 7, 1, 0, 1, 1, 1);
        // 88/7 is a bad address
        add(1, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 88, 7, 1, 0, 1, 1, 1);
        // scratch, fail, reset with a store pending, then pass
        add(1, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 80, 1, 0, 0, 0, 1, 1);
        add(0, 1, 90, 0, 1, 0, 1, 2, 2);
        add(1, 1, 84, 7, 0, 0, 0, 0, 0);
        add(0, 1, 84, 7, 0, 0, 0, 0, 0);  // IDLE->RUN edge ignores the store
        add(0, 1, 84, 7, 1, 1, 0, 1, 1);
        // deciding store on the last cycle before timeout still passes
        add(1, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 32'(k));
        add(0, 1, 84, 7, 1, 1, 0, 1, 10);
        add(0, 0,  0, 0, 1, 1, 0, 1, 10);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].we, vq[i].addr, vq[i].data);
            chk_all($sformatf("v%0d", i), vq[i].pass, vq[i].fail, vq[i].sc, vq[i].cc);
        end

        // ---------------- pass sequence, then held for 20 cycles
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all("rst", 0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 80, 3);
        step(0, 1, 80, 5);
        chk_all("scratch2", 0, 0, 2, 2);
        step(0, 1, 84, 7);
        chk_all("pass", 1, 0, 3, 3);
        for (int k = 0; k < 20; k++) begin
            step(0, k[0], (k[1] ? 32'd88 : 32'd80), 32'(k));
            chk_all($sformatf("hold%0d", k), 1, 0, 3, 3);
        end

        // ---------------- unknown address with strobe high
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b0; write_enab = 1'b1; data_addr = 'x; write_data = 32'd7;
        @(posedge clk); #1;
        write_enab = 1'b0; data_addr = '0;
        chk({"xaddr", ".fail"}, {31'd0, fail}, 32'd1);
        chk({"xaddr", ".pass"}, {31'd0, pass}, 32'd0);

        // ---------------- no stores: timeout or persistent RUN
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0);
        chk_all("to_edge", 0, 0, 0, 9);
        step(0, 0, 0, 0);
`ifdef STORE_MONITOR_TIMEOUT_EN
        chk_all("timeout", 0, 1, 0, 10);
        step(0, 1, 84, 7);
        chk_all("timeout_hold", 0, 1, 0, 10);
`else
        chk_all("no_timeout", 0, 0, 0, 10);
        step(0, 1, 80, 1);
        chk_all("still_run", 0, 0, 1, 11);
`endif

        // ---------------- saturation on a narrow counter
        sc_reset = 1'b1; sc_en = 1'b0;
        @(posedge clk); #1;
        sc_reset = 1'b0; sc_en = 1'b1;
        for (int k = 0; k < 6; k++) begin @(posedge clk); #1; end
        chk("sat6", {29'd0, sc_count}, 32'd6);
        @(posedge clk); #1;
        chk("sat7", {29'd0, sc_count}, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sat_hold", {29'd0, sc_count}, 32'd7);
        sc_en = 1'b0; sc_reset = 1'b1;
        @(posedge clk); #1;
        chk("sat_clr", {29'd0, sc_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
